hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core; drives the 2-bit Sel inputs of
//  both EX-stage operand forwarding muxes and the stall/bubble/flush controls.
//  Keeps its own shadow of rd/regwrite/memread for the EX, MEM and WB stages, fed from
//  ID-stage decode, so forwarding selects come from registered state.
//  Sits beside the pipeline registers and is clocked with them.
// PARAMETERS
//  LU_STALL   1   load-use stall cycles inserted per hazard (1..3)
//  CNT_W      16  width of saturating hazard statistics counter
// PORTS
//  clk             in   1      pipeline clock, all state on rising edge
//  rst_n           in   1      synchronous reset, active-low
//  id_valid        in   1      ID stage holds a real instruction
//  id_rs1          in   5      ID source reg 1
//  id_rs2          in   5      ID source reg 2
//  id_rd           in   5      ID destination reg
//  id_reg_write    in   1      ID instr writes rd
//  id_mem_read     in   1      ID instr is a load
//  ex_branch_taken in   1      EX-stage branch/jump resolved taken
//  mem_ready       in   1      data memory ready; 0 freezes whole pipeline
//  fwd_a_sel       out  2      operand A mux Sel: 00 ID/EX, 01 EX/MEM, 10 MEM/WB
//  fwd_b_sel       out  2      operand B mux Sel, same encoding
//  pc_stall        out  1      hold PC
//  ifid_stall      out  1      hold IF/ID register
//  idex_bubble     out  1      load NOP into ID/EX
//  flush           out  1      squash IF/ID and ID/EX
//  hazard_cnt      out  CNT_W  saturating count of load-use stall cycles
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=RUN, all shadow valid bits 0, stall ctr 0,
//   hazard_cnt 0; all outputs 0 in the following cycle (fwd sels 00).
//  Shadow stages EX/MEM/WB each hold {valid, rs1, rs2, rd, reg_write, mem_read}.
//  Advance (state!=MEM_WAIT and mem_ready=1): WB<=MEM, MEM<=EX, EX<=ID capture, except
//   EX<=bubble (valid=0) when idex_bubble or flush asserted that cycle.
//  Forwarding (combinational from shadow regs, per operand rsX of EX):
//   01 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rsX;
//   else 10 if same test on WB; else 00. MEM beats WB. 11 never driven.
//   EX.valid=0 -> 00.
//  Load-use hit: EX.valid & EX.mem_read & EX.rd!=0 & id_valid &
//   (EX.rd==id_rs1 | EX.rd==id_rs2).
//  FSM:
//   RUN: mem_ready=0 -> MEM_WAIT. Else ex_branch_taken -> flush=1, stay RUN.
//    Else load-use hit -> pc_stall=ifid_stall=idex_bubble=1, ctr<=LU_STALL-1,
//    go LU_STALL if LU_STALL>1 else stay RUN.
//   LU_STALL: pc_stall=ifid_stall=idex_bubble=1, ctr--; ctr==0 -> RUN.
//    ex_branch_taken -> flush=1, stall aborted, -> RUN. mem_ready=0 -> MEM_WAIT
//    (ctr kept, resumes LU_STALL after wait).
//   MEM_WAIT: pc_stall=ifid_stall=1, idex_bubble=flush=0, shadow frozen;
//    mem_ready=1 -> return state (RUN or LU_STALL) next cycle.
//  Priority: mem_ready=0 > ex_branch_taken > load-use. Flush and stall never together.
//  hazard_cnt +1 each cycle idex_bubble=1 due to load-use; saturates at all-ones.
//  Stall/flush outputs are combinational from state + inputs (same-cycle effect).
//  rst_n=0 mid-stall or mid-wait: abandons it, reset values next cycle.
// TESTING
//  ALU chain: add x5; next add uses x5 -> fwd_a_sel=01 one cycle, no stall.
//  Gap of one: add x5, nop, use x5 as rs2 -> fwd_b_sel=10; rd=x0 producer -> 00.
//  Both stages write x7, consumer reads x7 -> fwd_a_sel=01 (MEM priority).
//  lw x3; add uses x3 -> 1 cycle pc_stall/ifid_stall/idex_bubble, then sel=10,
//   hazard_cnt=1; LU_STALL=2 -> 2 stall cycles, hazard_cnt=2.
//  Branch taken during load-use -> flush=1, stall=0 that cycle, state RUN.
//  mem_ready=0 for 3 cycles mid-stall -> sels frozen, bubble=0; resume, finish stall;
//   rst_n=0 then -> all outputs 0, hazard_cnt 0.

Source files
------------

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the pipeline and the hazard/forwarding unit: ID decode and
// status going in, mux selects and stall/flush controls coming back.
interface hazard_forward_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_branch_taken;
  logic             mem_ready;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             flush;
  logic [CNT_W-1:0] hazard_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken, mem_ready,
    input  fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_bubble, flush,
           hazard_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           ex_branch_taken, mem_ready,
    output fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_bubble, flush,
           hazard_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: forwarding selects from a private EX/MEM/WB shadow,
// load-use stall insertion, taken-branch flush and data-memory wait freeze.
module hazard_forward_unit #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_unit_if.slave bus
);
  typedef enum logic [1:0] {S_RUN, S_LU_STALL, S_MEM_WAIT} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } ex_t;

  // Later stages only need what a producer contributes to forwarding.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } dst_t;

  localparam logic [1:0] CTR_INIT = 2'(LU_STALL - 1);

  state_t           state;
  state_t           ret_state;
  logic [1:0]       ctr;
  ex_t              ex_q;
  dst_t             mem_q;
  dst_t             wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lu_hit;
  logic             advance;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             flush;

  function automatic logic [1:0] fwd_sel(input logic ex_valid, input dst_t mem,
                                         input dst_t wb, input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_valid) begin
      if (mem.valid && mem.reg_write && mem.rd != 5'd0 && mem.rd == rs)
        sel = 2'b01;
      else if (wb.valid && wb.reg_write && wb.rd != 5'd0 && wb.rd == rs)
        sel = 2'b10;
    end
    return sel;
  endfunction

  assign lu_hit = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.id_valid &&
                  ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

  assign advance = (state != S_MEM_WAIT) && bus.mem_ready;

  // Memory wait outranks a taken branch, which outranks a load-use stall.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    unique case (state)
      S_RUN, S_LU_STALL: begin
        if (!bus.mem_ready) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
        end else if (bus.ex_branch_taken) begin
          flush = 1'b1;
        end else if (state == S_LU_STALL || lu_hit) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
      ctr       <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      cnt_q     <= '0;
    end else begin
      if (advance) begin
        wb_q  <= mem_q;
        mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
        if (idex_bubble || flush)
          ex_q <= '0;
        else
          ex_q <= '{valid: bus.id_valid, rs1: bus.id_rs1, rs2: bus.id_rs2,
                    rd: bus.id_rd, reg_write: bus.id_reg_write,
                    mem_read: bus.id_mem_read};
      end

      if (idex_bubble && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;

      // The counter holds remaining stall cycles; it is left alone across a memory wait.
      unique case (state)
        S_RUN: begin
          if (!bus.mem_ready) begin
            ret_state <= S_RUN;
            state     <= S_MEM_WAIT;
          end else if (!bus.ex_branch_taken && lu_hit) begin
            ctr <= CTR_INIT;
            if (LU_STALL > 1)
              state <= S_LU_STALL;
          end
        end
        S_LU_STALL: begin
          if (!bus.mem_ready) begin
            ret_state <= S_LU_STALL;
            state     <= S_MEM_WAIT;
          end else if (bus.ex_branch_taken) begin
            ctr   <= '0;
            state <= S_RUN;
          end else begin
            ctr <= ctr - 2'd1;
            if (ctr == 2'd1)
              state <= S_RUN;
          end
        end
        S_MEM_WAIT: begin
          if (bus.mem_ready)
            state <= ret_state;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.fwd_a_sel   = fwd_sel(ex_q.valid, mem_q, wb_q, ex_q.rs1);
  assign bus.fwd_b_sel   = fwd_sel(ex_q.valid, mem_q, wb_q, ex_q.rs2);
  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.idex_bubble = idex_bubble;
  assign bus.flush       = flush;
  assign bus.hazard_cnt  = cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (1-cycle and 2-cycle load-use, the second
// with a tiny counter to reach saturation) checked every cycle against a pipeline model.
module tb_hazard_forward_unit;
  localparam int LU_A = 1;
  localparam int CNT_A = 16;
  localparam int LU_B = 2;
  localparam int CNT_B = 2;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    instr_t ex;
    instr_t mem;
    instr_t wb;
    int     owed;
    logic   frozen;
    int     cnt;
  } model_t;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       bubble;
    logic       flush;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  in_t    cur;
  model_t ma;
  model_t mb;
  bit     model_ok = 1'b0;
  int     n_vec = 0;
  int     n_bad = 0;

  hazard_forward_unit_if #(.CNT_W(CNT_A)) bus_a ();
  hazard_forward_unit_if #(.CNT_W(CNT_B)) bus_b ();

  assign bus_a.id_valid        = cur.v;
  assign bus_a.id_rs1          = cur.rs1;
  assign bus_a.id_rs2          = cur.rs2;
  assign bus_a.id_rd           = cur.rd;
  assign bus_a.id_reg_write    = cur.rw;
  assign bus_a.id_mem_read     = cur.mr;
  assign bus_a.ex_branch_taken = cur.br;
  assign bus_a.mem_ready       = cur.rdy;
  assign bus_b.id_valid        = cur.v;
  assign bus_b.id_rs1          = cur.rs1;
  assign bus_b.id_rs2          = cur.rs2;
  assign bus_b.id_rd           = cur.rd;
  assign bus_b.id_reg_write    = cur.rw;
  assign bus_b.id_mem_read     = cur.mr;
  assign bus_b.ex_branch_taken = cur.br;
  assign bus_b.mem_ready       = cur.rdy;

  hazard_forward_unit #(.LU_STALL(LU_A), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  hazard_forward_unit #(.LU_STALL(LU_B), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Model: the nearest older writer of a register wins; x0 is never forwarded.
  function automatic logic [1:0] fwdOf(model_t m, logic [4:0] rs);
    instr_t older [2];
    older[0] = m.mem;
    older[1] = m.wb;
    if (!m.ex.v) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (older[i].v && older[i].rw && older[i].rd != 5'd0 && older[i].rd == rs)
        return 2'(i + 1);
    return 2'b00;
  endfunction

  function automatic exp_t modelOut(model_t m, in_t i);
    exp_t e;
    logic load_use;
    e = '0;
    e.fa = fwdOf(m, m.ex.rs1);
    e.fb = fwdOf(m, m.ex.rs2);
    load_use = m.ex.v && m.ex.mr && m.ex.rd != 5'd0 && i.v &&
               (m.ex.rd == i.rs1 || m.ex.rd == i.rs2);
    if (m.frozen || !i.rdy) e.stall = 1'b1;
    else if (i.br) e.flush = 1'b1;
    else if (m.owed > 0 || load_use) begin
      e.stall  = 1'b1;
      e.bubble = 1'b1;
    end
    return e;
  endfunction

  function automatic model_t modelStep(model_t m, in_t i, int lu, int cmax);
    exp_t   e;
    model_t n;
    e = modelOut(m, i);
    n = m;
    if (m.frozen) begin
      if (i.rdy) n.frozen = 1'b0;
      return n;
    end
    if (!i.rdy) begin
      n.frozen = 1'b1;
      return n;
    end
    n.wb  = m.mem;
    n.mem = m.ex;
    n.ex  = (e.bubble || e.flush) ? '0 : {i.v, i.rs1, i.rs2, i.rd, i.rw, i.mr};
    if (e.flush) n.owed = 0;
    else if (e.bubble) begin
      n.owed = (m.owed > 0) ? m.owed - 1 : lu - 1;
      if (m.cnt < cmax) n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ma       <= '0;
      mb       <= '0;
      model_ok <= 1'b1;
    end else begin
      ma <= modelStep(ma, cur, LU_A, (1 << CNT_A) - 1);
      mb <= modelStep(mb, cur, LU_B, (1 << CNT_B) - 1);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input int cnt,
                             input logic [1:0] fa, input logic [1:0] fb, input logic ps,
                             input logic is, input logic bb, input logic fl,
                             input logic [31:0] hc);
    cmp({tag, ".fwd_a_sel"}, 32'(fa), 32'(e.fa));
    cmp({tag, ".fwd_b_sel"}, 32'(fb), 32'(e.fb));
    cmp({tag, ".pc_stall"}, 32'(ps), 32'(e.stall));
    cmp({tag, ".ifid_stall"}, 32'(is), 32'(e.stall));
    cmp({tag, ".idex_bubble"}, 32'(bb), 32'(e.bubble));
    cmp({tag, ".flush"}, 32'(fl), 32'(e.flush));
    cmp({tag, ".hazard_cnt"}, hc, 32'(cnt));
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("A", modelOut(ma, cur), ma.cnt, bus_a.fwd_a_sel, bus_a.fwd_b_sel,
                  bus_a.pc_stall, bus_a.ifid_stall, bus_a.idex_bubble, bus_a.flush,
                  32'(bus_a.hazard_cnt));
      checkOutput("B", modelOut(mb, cur), mb.cnt, bus_b.fwd_a_sel, bus_b.fwd_b_sel,
                  bus_b.pc_stall, bus_b.ifid_stall, bus_b.idex_bubble, bus_b.flush,
                  32'(bus_b.hazard_cnt));
    end
  end

  function automatic in_t alu(int rd, int rs1, int rs2);
    return {1'b1, 5'(rs1), 5'(rs2), 5'(rd), 1'b1, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic in_t ld(int rd, int rs1);
    return {1'b1, 5'(rs1), 5'd0, 5'(rd), 1'b1, 1'b1, 1'b0, 1'b1};
  endfunction

  function automatic in_t nop();
    return {1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic in_t br(in_t v);
    in_t t;
    t = v;
    t.br = 1'b1;
    return t;
  endfunction

  function automatic in_t busy(in_t v);
    in_t t;
    t = v;
    t.rdy = 1'b0;
    return t;
  endfunction

  // Inputs change just after the rising edge; we return just after the falling edge.
  task automatic applyStimulus(input in_t v, input logic r);
    @(posedge clk);
    #1;
    cur   = v;
    rst_n = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    cur = nop();
    applyStimulus(nop(), 1'b0);
    applyStimulus(nop(), 1'b0);
    cmp("reset.pc_stall", 32'(bus_a.pc_stall), 0);
    cmp("reset.fwd_a_sel", 32'(bus_a.fwd_a_sel), 0);
    cmp("reset.hazard_cnt", 32'(bus_a.hazard_cnt), 0);

    // ALU chain: back-to-back dependency forwards from MEM.
    applyStimulus(alu(5, 1, 2), 1'b1);
    applyStimulus(alu(6, 5, 3), 1'b1);
    applyStimulus(nop(), 1'b1);
    cmp("chain.fwd_a_sel", 32'(bus_a.fwd_a_sel), 1);
    cmp("chain.fwd_b_sel", 32'(bus_a.fwd_b_sel), 0);
    cmp("chain.pc_stall", 32'(bus_a.pc_stall), 0);
    applyStimulus(nop(), 1'b1);

    // Gap of one: forwards from WB; an x0 producer never forwards.
    applyStimulus(alu(5, 1, 2), 1'b1);
    applyStimulus(nop(), 1'b1);
    applyStimulus(alu(8, 9, 5), 1'b1);
    applyStimulus(nop(), 1'b1);
    cmp("gap.fwd_b_sel", 32'(bus_a.fwd_b_sel), 2);
    applyStimulus(alu(0, 1, 2), 1'b1);
    applyStimulus(nop(), 1'b1);
    applyStimulus(alu(8, 9, 0), 1'b1);
    applyStimulus(nop(), 1'b1);
    cmp("x0.fwd_b_sel", 32'(bus_a.fwd_b_sel), 0);

    // Two writers of x7: the younger (MEM) wins.
    applyStimulus(alu(7, 1, 2), 1'b1);
    applyStimulus(alu(7, 3, 4), 1'b1);
    applyStimulus(alu(9, 7, 1), 1'b1);
    applyStimulus(nop(), 1'b1);
    cmp("prio.fwd_a_sel", 32'(bus_a.fwd_a_sel), 1);

    // Load-use on x3.
    applyStimulus(ld(3, 1), 1'b1);
    applyStimulus(alu(10, 3, 4), 1'b1);
    cmp("lu.A.idex_bubble", 32'(bus_a.idex_bubble), 1);
    cmp("lu.A.pc_stall", 32'(bus_a.pc_stall), 1);
    cmp("lu.B.idex_bubble", 32'(bus_b.idex_bubble), 1);
    applyStimulus(alu(10, 3, 4), 1'b1);
    cmp("lu.A.second_stall", 32'(bus_a.pc_stall), 0);
    cmp("lu.B.second_stall", 32'(bus_b.pc_stall), 1);
    applyStimulus(nop(), 1'b1);
    cmp("lu.A.fwd_a_sel", 32'(bus_a.fwd_a_sel), 2);
    cmp("lu.A.hazard_cnt", 32'(bus_a.hazard_cnt), 1);
    cmp("lu.B.hazard_cnt", 32'(bus_b.hazard_cnt), 2);

    // Taken branch in the load-use cycle, then in the middle of a 2-cycle stall.
    applyStimulus(ld(3, 1), 1'b1);
    applyStimulus(br(alu(10, 3, 4)), 1'b1);
    cmp("br.A.flush", 32'(bus_a.flush), 1);
    cmp("br.A.pc_stall", 32'(bus_a.pc_stall), 0);
    cmp("br.A.idex_bubble", 32'(bus_a.idex_bubble), 0);
    applyStimulus(nop(), 1'b1);
    applyStimulus(ld(3, 1), 1'b1);
    applyStimulus(alu(10, 3, 4), 1'b1);
    applyStimulus(br(alu(10, 3, 4)), 1'b1);
    cmp("brmid.B.flush", 32'(bus_b.flush), 1);
    cmp("brmid.B.pc_stall", 32'(bus_b.pc_stall), 0);
    applyStimulus(nop(), 1'b1);
    cmp("brmid.B.after", 32'(bus_b.pc_stall), 0);
    cmp("brmid.A.hazard_cnt", 32'(bus_a.hazard_cnt), 2);
    cmp("brmid.B.hazard_cnt", 32'(bus_b.hazard_cnt), 3);

    // Saturation of the 2-bit counter.
    applyStimulus(ld(3, 1), 1'b1);
    applyStimulus(alu(10, 3, 4), 1'b1);
    applyStimulus(alu(10, 3, 4), 1'b1);
    applyStimulus(nop(), 1'b1);
    cmp("sat.A.hazard_cnt", 32'(bus_a.hazard_cnt), 3);
    cmp("sat.B.hazard_cnt", 32'(bus_b.hazard_cnt), 3);

    // Memory wait in the middle of the 2-cycle stall.
    applyStimulus(ld(4, 1), 1'b1);
    applyStimulus(alu(12, 4, 4), 1'b1);
    applyStimulus(busy(alu(12, 4, 4)), 1'b1);
    cmp("wait.B.idex_bubble", 32'(bus_b.idex_bubble), 0);
    cmp("wait.B.pc_stall", 32'(bus_b.pc_stall), 1);
    applyStimulus(busy(alu(12, 4, 4)), 1'b1);
    applyStimulus(busy(alu(12, 4, 4)), 1'b1);
    applyStimulus(alu(12, 4, 4), 1'b1);
    cmp("wait.A.release_stall", 32'(bus_a.pc_stall), 1);
    applyStimulus(alu(12, 4, 4), 1'b1);
    cmp("resume.B.idex_bubble", 32'(bus_b.idex_bubble), 1);
    cmp("resume.A.pc_stall", 32'(bus_a.pc_stall), 0);
    applyStimulus(nop(), 1'b1);
    cmp("resume.A.fwd_a_sel", 32'(bus_a.fwd_a_sel), 2);
    cmp("resume.A.fwd_b_sel", 32'(bus_a.fwd_b_sel), 2);
    cmp("resume.A.hazard_cnt", 32'(bus_a.hazard_cnt), 4);

    // Reset while waiting on memory.
    applyStimulus(busy(nop()), 1'b1);
    applyStimulus(nop(), 1'b0);
    applyStimulus(nop(), 1'b1);
    cmp("rst.A.pc_stall", 32'(bus_a.pc_stall), 0);
    cmp("rst.B.pc_stall", 32'(bus_b.pc_stall), 0);
    cmp("rst.A.hazard_cnt", 32'(bus_a.hazard_cnt), 0);
    cmp("rst.B.hazard_cnt", 32'(bus_b.hazard_cnt), 0);
    cmp("rst.A.fwd_a_sel", 32'(bus_a.fwd_a_sel), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
